// File: rtl/alu_mem_stage_if.sv
// Execute/memory stage bus: control, operands and stage results of the 16-bit CPU.
// The master drives decode/operand/memory-control fields; the slave returns ALU and memory results.
interface alu_mem_stage_if;
  logic [1:0]  ALUOp;
  logic [3:0]  Opcode;
  logic [1:0]  Funct;
  logic [15:0] ReadData1;
  logic [15:0] ReadData2;
  logic [7:0]  Imm8;
  logic        ALUSrc;
  logic        Shift;
  logic [15:0] ShiftResult;
  logic        MemRead;
  logic        MemWrite;
  logic        MemToReg;
  logic [3:0]  ALUCtrl;
  logic [15:0] ALUResult;
  logic        Zero;
  logic        Overflow;
  logic        CarryOut;
  logic [15:0] StageResult;
  logic [15:0] MemData;
  logic [15:0] WriteData;

  modport master (
    output ALUOp, Opcode, Funct, ReadData1, ReadData2, Imm8, ALUSrc, Shift,
           ShiftResult, MemRead, MemWrite, MemToReg,
    input  ALUCtrl, ALUResult, Zero, Overflow, CarryOut, StageResult, MemData, WriteData
  );

  modport slave (
    input  ALUOp, Opcode, Funct, ReadData1, ReadData2, Imm8, ALUSrc, Shift,
           ShiftResult, MemRead, MemWrite, MemToReg,
    output ALUCtrl, ALUResult, Zero, Overflow, CarryOut, StageResult, MemData, WriteData
  );
endinterface

// File: rtl/alu_mem_stage.sv
// Execute + memory stage: ALU control decode, 16-bit ALU, shifter select,
// byte-addressed little-endian data memory and write-back select.
module alu_mem_stage #(
  parameter int MEM_BYTES = 256,
  parameter int ADDR_BITS = 8
) (
  input  logic           Clock,
  input  logic           Reset_n,
  alu_mem_stage_if.slave bus
);

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_XOR = 4'b0011;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;

  logic [3:0]        alu_ctrl;
  logic signed [15:0] op_a;
  logic signed [15:0] op_b;
  logic [16:0]       sum_w;
  logic [16:0]       diff_w;
  logic [15:0]       alu_res;
  logic              alu_ov;
  logic              alu_co;
  logic [15:0]       stage_res;
  logic [15:0]       mem_rd;
  logic [ADDR_BITS-1:0] addr_lo;
  logic [ADDR_BITS-1:0] addr_hi;
  logic [7:0]        mem [MEM_BYTES];

  always_comb begin
    alu_ctrl = CTRL_ADD;
    unique case (bus.ALUOp)
      2'b00: alu_ctrl = CTRL_ADD;
      2'b01: alu_ctrl = CTRL_SUB;
      2'b10: begin
        if (bus.Opcode == 4'b0000) begin
          unique case (bus.Funct)
            2'b00: alu_ctrl = CTRL_ADD;
            2'b01: alu_ctrl = CTRL_SUB;
            2'b10: alu_ctrl = CTRL_SLT;
            2'b11: alu_ctrl = CTRL_NOR;
          endcase
        end else if (bus.Opcode == 4'b0001) begin
          unique case (bus.Funct)
            2'b00: alu_ctrl = CTRL_AND;
            2'b01: alu_ctrl = CTRL_OR;
            2'b10: alu_ctrl = CTRL_XOR;
            2'b11: alu_ctrl = CTRL_NOR;
          endcase
        end
      end
      2'b11: begin
        case (bus.Opcode)
          4'b0100: alu_ctrl = CTRL_ADD;
          4'b0101: alu_ctrl = CTRL_SUB;
          4'b0110: alu_ctrl = CTRL_SLT;
          4'b0111: alu_ctrl = CTRL_AND;
          4'b1000: alu_ctrl = CTRL_OR;
          4'b1001: alu_ctrl = CTRL_XOR;
          default: alu_ctrl = CTRL_ADD;
        endcase
      end
    endcase
  end

  assign op_a   = bus.ReadData1;
  assign op_b   = bus.ALUSrc ? {{8{bus.Imm8[7]}}, bus.Imm8} : bus.ReadData2;
  // Subtraction as A + ~B + 1 so bit 16 is the no-borrow flag.
  assign sum_w  = {1'b0, op_a} + {1'b0, op_b};
  assign diff_w = {1'b0, op_a} + {1'b0, ~op_b} + 17'd1;

  always_comb begin
    alu_res = 16'h0000;
    alu_ov  = 1'b0;
    alu_co  = 1'b0;
    case (alu_ctrl)
      CTRL_AND: alu_res = op_a & op_b;
      CTRL_OR:  alu_res = op_a | op_b;
      CTRL_XOR: alu_res = op_a ^ op_b;
      CTRL_NOR: alu_res = ~(op_a | op_b);
      CTRL_ADD: begin
        alu_res = sum_w[15:0];
        alu_co  = sum_w[16];
        alu_ov  = (op_a[15] == op_b[15]) && (sum_w[15] != op_a[15]);
      end
      CTRL_SUB: begin
        alu_res = diff_w[15:0];
        alu_co  = diff_w[16];
        alu_ov  = (op_a[15] != op_b[15]) && (diff_w[15] != op_a[15]);
      end
      CTRL_SLT: alu_res = {15'd0, (op_a < op_b)};
      default:  alu_res = 16'h0000;
    endcase
  end

  assign stage_res = bus.Shift ? bus.ShiftResult : alu_res;

  // Halfword-aligned address; upper result bits wrap modulo MEM_BYTES.
  assign addr_lo = {stage_res[ADDR_BITS-1:1], 1'b0};
  assign addr_hi = {stage_res[ADDR_BITS-1:1], 1'b1};

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'h00;
    end else if (bus.MemWrite) begin
      mem[addr_lo] <= bus.ReadData2[7:0];
      mem[addr_hi] <= bus.ReadData2[15:8];
    end
  end

  assign mem_rd = bus.MemRead ? {mem[addr_hi], mem[addr_lo]} : 16'h0000;

  assign bus.ALUCtrl     = alu_ctrl;
  assign bus.ALUResult   = alu_res;
  assign bus.Zero        = ~|alu_res;
  assign bus.Overflow    = alu_ov;
  assign bus.CarryOut    = alu_co;
  assign bus.StageResult = stage_res;
  assign bus.MemData     = mem_rd;
  assign bus.WriteData   = bus.MemToReg ? mem_rd : stage_res;

endmodule

// File: tb/tb_alu_mem_stage.sv
// Self-checking bench for alu_mem_stage: directed test-plan steps followed by
// randomized vectors compared against an arithmetic reference model.
module tb_alu_mem_stage;

  logic Clock;
  logic Reset_n;
  int   n_checks;
  int   n_errors;

  alu_mem_stage_if ifc ();

  alu_mem_stage #(.MEM_BYTES(256), .ADDR_BITS(8)) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (ifc)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef enum int {OP_AND, OP_OR, OP_ADD, OP_XOR, OP_SUB, OP_SLT, OP_NOR} op_e;
  typedef struct {
    logic [3:0]  ctrl;
    logic [15:0] res;
    logic        z;
    logic        ov;
    logic        co;
  } alu_exp_t;

  logic [7:0] mdl_mem [256];

  function automatic op_e decode_op(logic [1:0] aluop, logic [3:0] opc, logic [1:0] fn);
    if (aluop == 2'd0) return OP_ADD;
    if (aluop == 2'd1) return OP_SUB;
    if (aluop == 2'd2) begin
      if (opc == 4'd0) begin
        if (fn == 2'd0) return OP_ADD;
        if (fn == 2'd1) return OP_SUB;
        if (fn == 2'd2) return OP_SLT;
        return OP_NOR;
      end
      if (opc == 4'd1) begin
        if (fn == 2'd0) return OP_AND;
        if (fn == 2'd1) return OP_OR;
        if (fn == 2'd2) return OP_XOR;
        return OP_NOR;
      end
      return OP_ADD;
    end
    if (opc == 4'd5) return OP_SUB;
    if (opc == 4'd6) return OP_SLT;
    if (opc == 4'd7) return OP_AND;
    if (opc == 4'd8) return OP_OR;
    if (opc == 4'd9) return OP_XOR;
    return OP_ADD;
  endfunction

  function automatic logic [3:0] op_code(op_e op);
    case (op)
      OP_AND:  return 4'b0000;
      OP_OR:   return 4'b0001;
      OP_ADD:  return 4'b0010;
      OP_XOR:  return 4'b0011;
      OP_SUB:  return 4'b0110;
      OP_SLT:  return 4'b0111;
      default: return 4'b1100;
    endcase
  endfunction

  function automatic alu_exp_t ref_alu();
    alu_exp_t    e;
    op_e         op;
    int          ua, ub, sa, sb, us, ss;
    logic [31:0] tmp;
    ua = int'(ifc.ReadData1);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    if (ifc.ALUSrc) begin
      sb = (int'(ifc.Imm8) >= 128) ? int'(ifc.Imm8) - 256 : int'(ifc.Imm8);
      ub = (sb < 0) ? sb + 65536 : sb;
    end else begin
      ub = int'(ifc.ReadData2);
      sb = (ub >= 32768) ? ub - 65536 : ub;
    end
    op     = decode_op(ifc.ALUOp, ifc.Opcode, ifc.Funct);
    e.ctrl = op_code(op);
    e.ov   = 1'b0;
    e.co   = 1'b0;
    tmp    = 32'd0;
    case (op)
      OP_AND: tmp = 32'(ua & ub);
      OP_OR:  tmp = 32'(ua | ub);
      OP_XOR: tmp = 32'(ua ^ ub);
      OP_NOR: tmp = 32'(~(ua | ub));
      OP_SLT: tmp = (sa < sb) ? 32'd1 : 32'd0;
      OP_ADD: begin
        us = ua + ub; ss = sa + sb;
        tmp = 32'(us);
        e.co = (us > 65535);
        e.ov = (ss > 32767) || (ss < -32768);
      end
      default: begin
        us = ua - ub; ss = sa - sb;
        tmp = 32'(us);
        e.co = (ua >= ub);
        e.ov = (ss > 32767) || (ss < -32768);
      end
    endcase
    e.res = tmp[15:0];
    e.z   = (e.res == 16'h0000);
    return e;
  endfunction

  function automatic logic [15:0] mdl_stage();
    alu_exp_t e;
    e = ref_alu();
    return ifc.Shift ? ifc.ShiftResult : e.res;
  endfunction

  function automatic logic [15:0] mdl_read(logic [15:0] addr);
    int a;
    a = int'(addr) % 256;
    a = a - (a % 2);
    return {mdl_mem[a+1], mdl_mem[a]};
  endfunction

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    alu_exp_t    e;
    logic [15:0] es, em, ew;
    #1;
    e  = ref_alu();
    es = ifc.Shift ? ifc.ShiftResult : e.res;
    em = ifc.MemRead ? mdl_read(es) : 16'h0000;
    ew = ifc.MemToReg ? em : es;
    chk({tag, ".ctrl"},  {12'd0, ifc.ALUCtrl}, {12'd0, e.ctrl});
    chk({tag, ".res"},   ifc.ALUResult, e.res);
    chk({tag, ".zero"},  {15'd0, ifc.Zero}, {15'd0, e.z});
    chk({tag, ".ovf"},   {15'd0, ifc.Overflow}, {15'd0, e.ov});
    chk({tag, ".cout"},  {15'd0, ifc.CarryOut}, {15'd0, e.co});
    chk({tag, ".stage"}, ifc.StageResult, es);
    chk({tag, ".mdata"}, ifc.MemData, em);
    chk({tag, ".wdata"}, ifc.WriteData, ew);
  endtask

  // Mirror of the clock edge that just happened, using the inputs held across it.
  task automatic commit_edge();
    logic [15:0] s;
    int a;
    if (ifc.MemWrite && Reset_n) begin
      s = mdl_stage();
      a = int'(s) % 256;
      a = a - (a % 2);
      mdl_mem[a]   = ifc.ReadData2[7:0];
      mdl_mem[a+1] = ifc.ReadData2[15:8];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) mdl_mem[i] = 8'h00;
  endtask

  task automatic idle_inputs();
    ifc.ALUOp = 2'd0; ifc.Opcode = 4'd0; ifc.Funct = 2'd0;
    ifc.ReadData1 = 16'h0; ifc.ReadData2 = 16'h0; ifc.Imm8 = 8'h0;
    ifc.ALUSrc = 1'b0; ifc.Shift = 1'b0; ifc.ShiftResult = 16'h0;
    ifc.MemRead = 1'b0; ifc.MemWrite = 1'b0; ifc.MemToReg = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_reset();
    idle_inputs();
    Reset_n = 1'b0;
    ifc.MemRead = 1'b1;
    ifc.ReadData1 = 16'h0040;
    check_all("reset");
    chk("reset.mem0", ifc.MemData, 16'h0000);
    @(negedge Clock);
    @(negedge Clock);
    Reset_n = 1'b1;

    // Signed overflow on R-type ADD
    @(negedge Clock);
    idle_inputs();
    ifc.ALUOp = 2'b10; ifc.ReadData1 = 16'h7FFF; ifc.ReadData2 = 16'h0001;
    check_all("add");
    chk("add.res_k", ifc.ALUResult, 16'h8000);
    chk("add.ovf_k", {15'd0, ifc.Overflow}, 16'd1);
    chk("add.co_k",  {15'd0, ifc.CarryOut}, 16'd0);

    ifc.ALUOp = 2'b01; ifc.ReadData1 = 16'h1234; ifc.ReadData2 = 16'h1234;
    check_all("sub_eq");
    chk("sub_eq.zero_k", {15'd0, ifc.Zero}, 16'd1);
    chk("sub_eq.co_k",   {15'd0, ifc.CarryOut}, 16'd1);

    ifc.ReadData1 = 16'h0001; ifc.ReadData2 = 16'h0002;
    check_all("sub_lt");
    chk("sub_lt.res_k", ifc.ALUResult, 16'hFFFF);
    chk("sub_lt.co_k",  {15'd0, ifc.CarryOut}, 16'd0);

    ifc.ALUOp = 2'b11; ifc.Opcode = 4'b0110; ifc.ALUSrc = 1'b1;
    ifc.ReadData1 = 16'hFFFE; ifc.Imm8 = 8'hFF;
    check_all("slti");
    chk("slti.res_k", ifc.ALUResult, 16'h0001);

    // Store BEEF at 0x14, then read it back directly and through a wrapped address
    idle_inputs();
    ifc.ALUSrc = 1'b1; ifc.ReadData1 = 16'h0010; ifc.Imm8 = 8'h04;
    ifc.ReadData2 = 16'hBEEF; ifc.MemWrite = 1'b1;
    check_all("store");
    @(posedge Clock);
    commit_edge();
    @(negedge Clock);
    ifc.MemWrite = 1'b0; ifc.MemRead = 1'b1; ifc.MemToReg = 1'b1;
    check_all("load");
    chk("load.mdata_k", ifc.MemData, 16'hBEEF);
    chk("load.wdata_k", ifc.WriteData, 16'hBEEF);
    ifc.ReadData1 = 16'h0111;
    check_all("load_wrap");
    chk("load_wrap.mdata_k", ifc.MemData, 16'hBEEF);

    ifc.Shift = 1'b1; ifc.ShiftResult = 16'h00F0; ifc.MemToReg = 1'b0;
    check_all("shift");
    chk("shift.wdata_k", ifc.WriteData, 16'h00F0);

    // Read and write the same word in one cycle
    @(negedge Clock);
    ifc.Shift = 1'b0; ifc.ReadData1 = 16'h0010; ifc.MemToReg = 1'b1;
    ifc.MemWrite = 1'b1; ifc.ReadData2 = 16'h1357;
    check_all("rw_pre");
    chk("rw_pre.mdata_k", ifc.MemData, 16'hBEEF);
    @(posedge Clock);
    commit_edge();
    check_all("rw_post");
    chk("rw_post.mdata_k", ifc.MemData, 16'h1357);

    // Mid-cycle reset pulse clears memory and blocks a write edge
    @(negedge Clock);
    ifc.MemWrite = 1'b0;
    #2;
    Reset_n = 1'b0;
    model_reset();
    check_all("rst_pulse");
    chk("rst_pulse.mdata_k", ifc.MemData, 16'h0000);
    ifc.MemWrite = 1'b1; ifc.ReadData2 = 16'hA5A5;
    @(posedge Clock);
    commit_edge();
    @(negedge Clock);
    ifc.MemWrite = 1'b0;
    check_all("rst_blk");
    chk("rst_blk.mdata_k", ifc.MemData, 16'h0000);
    #2;
    Reset_n = 1'b1;
    check_all("rst_rel");

    for (int i = 0; i < 300; i++) begin
      @(negedge Clock);
      ifc.ALUOp       = 2'($urandom_range(0, 3));
      ifc.Opcode      = 4'($urandom_range(0, 15));
      ifc.Funct       = 2'($urandom_range(0, 3));
      ifc.ReadData1   = 16'($urandom);
      ifc.ReadData2   = 16'($urandom);
      ifc.Imm8        = 8'($urandom);
      ifc.ALUSrc      = 1'($urandom_range(0, 1));
      ifc.Shift       = ($urandom_range(0, 7) == 0);
      ifc.ShiftResult = 16'($urandom);
      ifc.MemRead     = 1'($urandom_range(0, 1));
      ifc.MemWrite    = ($urandom_range(0, 3) == 0);
      ifc.MemToReg    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        ifc.ALUOp = 2'b00; ifc.ALUSrc = 1'b1; ifc.Shift = 1'b0;
        ifc.ReadData1 = 16'($urandom_range(0, 40));
        ifc.Imm8 = 8'($urandom_range(0, 30));
      end
      check_all("rnd_pre");
      @(posedge Clock);
      commit_edge();
      check_all("rnd_post");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_mem_stage.md
Name: alu_mem_stage

Overview:
- Execute + memory stage of the 16-bit single-cycle CPU.
- Decodes ALU control from ALUOp/opcode/funct, runs the 16-bit ALU on a register or sign-extended-immediate operand, and selects ALU or external shifter result as the stage result.
- Accesses a byte-addressed 16-bit data memory and produces the write-back value.
- Sits between the register file/shifter and register write-back; Zero feeds the branch logic.

Parameters:
- MEM_BYTES, 256, data memory size in bytes (power of two).
- ADDR_BITS, 8, log2(MEM_BYTES); address bits used from the stage result.

Ports:
- Clock  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous active-low reset.
- ALUOp  input  2  ALU operation class from main control.
- Opcode  input  4  instruction[15:12].
- Funct  input  2  instruction[1:0].
- ReadData1  input  16  operand A (rs).
- ReadData2  input  16  rt value; operand B when ALUSrc=0; store data.
- Imm8  input  8  instruction[7:0].
- ALUSrc  input  1  1 = B is sign-extended Imm8.
- Shift  input  1  1 = stage result is ShiftResult.
- ShiftResult  input  16  external shifter output.
- MemRead  input  1  enables memory read data.
- MemWrite  input  1  synchronous store enable.
- MemToReg  input  1  1 = write-back takes memory data.
- ALUCtrl  output  4  decoded ALU control.
- ALUResult  output  16  raw ALU result.
- Zero  output  1  ALUResult == 0.
- Overflow  output  1  signed overflow.
- CarryOut  output  1  carry/no-borrow.
- StageResult  output  16  Shift ? ShiftResult : ALUResult; also the memory address.
- MemData  output  16  memory read data.
- WriteData  output  16  MemToReg ? MemData : StageResult.

Behaviour:
- ALUCtrl codes: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB, 0111 SLT, 1100 NOR. Any other code gives result 0 with all flags 0.
- ALUCtrl decode:
  - ALUOp 00: ADD (load/store address).
  - ALUOp 01: SUB (beq).
  - ALUOp 10 (R-type), Opcode 0000: Funct 00 ADD, 01 SUB, 10 SLT, 11 NOR.
  - ALUOp 10, Opcode 0001: Funct 00 AND, 01 OR, 10 XOR, 11 NOR.
  - ALUOp 10, any other Opcode: ADD.
  - ALUOp 11 (I-type), by Opcode: 0100 ADD, 0101 SUB, 0110 SLT, 0111 AND, 1000 OR, 1001 XOR; other opcodes ADD.
- Operand B = ALUSrc ? {{8{Imm8[7]}},Imm8} : ReadData2. ALU carry-in is 0.
- ADD:
  - 17-bit sum; CarryOut = bit 16.
  - Overflow = operands same sign and result sign differs.
- SUB:
  - A + ~B + 1; CarryOut = 1 when no borrow (A >= B unsigned).
  - Overflow = operands differ in sign and result sign differs from A.
- SLT: result 16'h0001 if A < B signed, else 0. CarryOut = 0, Overflow = 0.
- Logic ops: CarryOut = 0, Overflow = 0.
- Zero = ~|ALUResult for all ops.
- ALU, decode and muxes are purely combinational; they are not affected by Reset_n.
- Data memory, byte array MEM_BYTES:
  - Address = StageResult[ADDR_BITS-1:0] with bit 0 forced to 0 (halfword aligned).
  - Upper address bits are ignored, so addresses wrap modulo MEM_BYTES.
  - Little-endian: low byte at addr, high byte at addr+1.
- Read: combinational. MemData = word at address when MemRead=1, else 16'h0000.
- Write: on rising Clock when MemWrite=1 and Reset_n=1, the word at the address takes ReadData2. It is visible to a combinational read immediately after the edge.
- MemRead and MemWrite both high, same address: MemData shows old contents until the edge, then new data.
- Reset_n=0: immediately clears all memory bytes to 0 (MemData reads 0) and blocks writes. Deasserting Reset_n mid-cycle takes effect at the next edge.
- Outputs have no registered state. After reset, MemData = 0 for any address; other outputs follow inputs.

Test Plan:
- ADD with ALUOp=10, Opcode=0000, Funct=00, A=16'h7FFF, B=16'h0001 -> ALUResult=16'h8000, Overflow=1, CarryOut=0, Zero=0.
- SUB with ALUOp=01, A=B=16'h1234 -> ALUResult=0, Zero=1, CarryOut=1, Overflow=0. Same op with A=16'h0001, B=16'h0002 -> 16'hFFFF, CarryOut=0.
- I-type SLT with ALUOp=11, Opcode=0110, ALUSrc=1, A=16'hFFFE, Imm8=8'hFF -> B=16'hFFFF, ALUResult=16'h0001.
- Store then load:
  - Store: ALUOp=00, A=16'h0010, Imm8=8'h04, ReadData2=16'hBEEF, MemWrite=1, one edge.
  - Load: MemRead=1, MemToReg=1 -> MemData=16'hBEEF, WriteData=16'hBEEF. Address 16'h0115 (wraps, bit0 dropped to 0x14) also returns 16'hBEEF.
- Shift path: Shift=1, ShiftResult=16'h00F0, MemToReg=0 -> StageResult=WriteData=16'h00F0 regardless of ALU.
- Pulse Reset_n low between clock edges after a store -> MemData reads 0 immediately. A MemWrite edge while Reset_n=0 leaves memory at 0.
